drive_cmd_arbiter: RTL
======================

// Module: drive_cmd_arbiter
// PURPOSE
//  Parametrised successor to the single-source drive FSM. Arbitrates N_SRC command sources
//  (IR remote, camera tracker, mic) by fixed priority, with a per-source lease timeout.
//  Ramps drive speed and forces a brake-to-zero before any direction change. Adds a latched
//  e-stop. Sits between the sensor front-ends and the motor/HEX status logic in top_level.
// PARAMETERS
//  N_SRC      3          number of command sources; index 0 = highest priority
//  CMD_W      3          command code width; codes 0=STOP 1=FWD 2=BACK 3=LEFT 4=RIGHT, others invalid
//  SPEED_W    2          speed width; max speed = 2**SPEED_W-1
//  LEASE_CYC  5_000_000  cycles a latched source command stays live (100 ms at 50 MHz), >=1
//  RAMP_CYC   1_250_000  cycles per +/-1 speed step, >=1
// PORTS
//  clk_50        in   1                  system clock
//  reset         in   1                  synchronous, active-high reset
//  src_valid     in   N_SRC              per-source 1-cycle command strobe
//  src_cmd       in   N_SRC*CMD_W        packed commands; source i at [i*CMD_W +: CMD_W]
//  src_speed     in   N_SRC*SPEED_W      packed requested speeds, same packing
//  estop         in   1                  emergency stop level
//  estop_clear   in   1                  1-cycle pulse to leave ESTOP
//  drive_cmd     out  CMD_W              registered applied command
//  drive_speed   out  SPEED_W            registered applied speed
//  active_src    out  $clog2(N_SRC)      index of the winning live source (0 when none)
//  active_valid  out  1                  some source lease is live
//  state         out  2                  0=STOP 1=RUN 2=BRAKE 3=ESTOP
//  cmd_changed   out  1                  1-cycle pulse when drive_cmd changes value
//  cmd_reject    out  1                  1-cycle pulse: a strobed command had an invalid code
// BEHAVIOUR
//  Reset: all outputs 0, state=STOP, all leases 0, ramp timer 0.
//  Lease: a src_valid[i] strobe with a valid code at edge k latches cmd/speed and loads lease_i=LEASE_CYC.
//   Otherwise lease_i decrements to 0 and saturates there. Source i is live while lease_i>0. A reload in
//   the expiry cycle wins. An invalid code leaves the lease untouched and pulses cmd_reject at k+1.
//   An explicit STOP from a live source holds priority like any other command.
//  Target: the lowest-index live source supplies target_cmd/target_speed (combinational from the lease regs).
//   With no live source: target=STOP, speed 0.
//  Latency: the FSM reacts at edge k+1 to a strobe at edge k.
//  Ramp timer: loads RAMP_CYC-1 on every state entry and after each step; a step occurs when it reads 0.
//  STOP: drive_cmd=0, speed=0. Go to RUN when target_cmd!=STOP and target_speed>0, setting drive_cmd=target_cmd
//   and keeping speed at 0.
//  RUN, target_cmd==drive_cmd: speed steps +/-1 toward target_speed per ramp step; it never overshoots and never
//   wraps past max.
//  RUN, target_cmd!=drive_cmd (including STOP or lease expiry): go to BRAKE; drive_cmd is held.
//  BRAKE: speed -1 per step. At speed==0, go to STOP and set drive_cmd=0.
//   If target_cmd returns to drive_cmd during BRAKE, go back to RUN and resume the ramp.
//  ESTOP: entered from any state on the edge estop is seen high, with priority over all else. That edge sets
//   drive_cmd=0, speed=0 and clears all leases. Strobes are ignored while in ESTOP.
//   Exit to STOP only on estop_clear with estop low in the same cycle.
//  A reset asserted mid-operation returns everything to the reset values on that edge.
//  cmd_changed is asserted in the cycle after the drive_cmd register takes a new value.
// TESTING  (N_SRC=3, LEASE_CYC=20, RAMP_CYC=4, SPEED_W=2)
//  Src1 FWD speed3 strobe -> RUN next edge; speed 0->1->2->3 every 4 cycles; lease expiry -> BRAKE -> 3..0 -> STOP.
//  Src1 FWD live, then src0 LEFT speed1 -> BRAKE to 0, STOP, RUN LEFT, speed rises to 1, active_src=0.
//  Src2 cmd=7 strobe -> cmd_reject 1-cycle pulse; state and leases unchanged.
//  RUN FWD speed2, estop=1 -> next edge ESTOP, speed 0, cmd 0; estop_clear while estop=1 is ignored;
//   estop=0 plus clear -> STOP.
//  Src1 re-strobes FWD in its lease expiry cycle -> no BRAKE, speed unchanged, lease=20.
//  Reset pulse mid-ramp -> all outputs 0, state=STOP on that edge; src0 strobe next cycle is accepted normally.

Source files
------------

// File: rtl/drive_cmd_arbiter.sv
// Fixed-priority drive command arbiter with per-source leases, speed ramping,
// forced brake-to-zero before any direction change, and a latched e-stop.
//
// state  | meaning
// STOP   | motor idle, drive_cmd=STOP, speed 0
// RUN    | drive_cmd applied, speed ramps toward the live target speed
// BRAKE  | target direction differs, speed ramps down to 0 before STOP
// ESTOP  | latched emergency stop, strobes ignored until estop_clear
module drive_cmd_arbiter #(
   parameter int N_SRC     = 3,
   parameter int CMD_W     = 3,
   parameter int SPEED_W   = 2,
   parameter int LEASE_CYC = 5_000_000,
   parameter int RAMP_CYC  = 1_250_000
) (
   input  logic                       clk_50,
   input  logic                       reset,
   input  logic [N_SRC-1:0]           src_valid,
   input  logic [N_SRC*CMD_W-1:0]     src_cmd,
   input  logic [N_SRC*SPEED_W-1:0]   src_speed,
   input  logic                       estop,
   input  logic                       estop_clear,
   output logic [CMD_W-1:0]           drive_cmd,
   output logic [SPEED_W-1:0]         drive_speed,
   output logic [$clog2(N_SRC)-1:0]   active_src,
   output logic                       active_valid,
   output logic [1:0]                 state,
   output logic                       cmd_changed,
   output logic                       cmd_reject
);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_BRAKE = 2'd2,
      ST_ESTOP = 2'd3
   } state_t;

   localparam int IDX_W = $clog2(N_SRC);
   localparam int LW    = $clog2(LEASE_CYC + 1);
   localparam int RW    = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
   localparam logic [CMD_W-1:0] CMD_STOP   = '0;
   localparam logic [LW-1:0]    LEASE_LOAD = LW'(LEASE_CYC);
   localparam logic [RW-1:0]    RAMP_LOAD  = RW'(RAMP_CYC - 1);

   state_t               state_q, state_d;
   logic [CMD_W-1:0]     drive_cmd_q, drive_cmd_d;
   logic [SPEED_W-1:0]   speed_q, speed_d;
   logic [RW-1:0]        ramp_q, ramp_d;
   logic                 cmd_changed_q, cmd_changed_d;
   logic                 cmd_reject_q, cmd_reject_d;
   logic [LW-1:0]        lease_q [N_SRC];
   logic [LW-1:0]        lease_d [N_SRC];
   logic [CMD_W-1:0]     lcmd_q  [N_SRC];
   logic [CMD_W-1:0]     lcmd_d  [N_SRC];
   logic [SPEED_W-1:0]   lspd_q  [N_SRC];
   logic [SPEED_W-1:0]   lspd_d  [N_SRC];

   logic                 tgt_valid;
   logic [IDX_W-1:0]     tgt_idx;
   logic [CMD_W-1:0]     tgt_cmd;
   logic [SPEED_W-1:0]   tgt_spd;
   logic                 accept_en;

   function automatic logic code_ok(input logic [CMD_W-1:0] c);
      return (c <= CMD_W'(4));
   endfunction

   // Strobes are dropped on an estop edge and while latched in ESTOP.
   assign accept_en = !estop && (state_q != ST_ESTOP);

   always_comb begin
      cmd_reject_d = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         lease_d[i] = lease_q[i];
         lcmd_d[i]  = lcmd_q[i];
         lspd_d[i]  = lspd_q[i];
         if (estop) begin
            lease_d[i] = '0;
         end else if (accept_en && src_valid[i] && code_ok(src_cmd[i*CMD_W +: CMD_W])) begin
            lease_d[i] = LEASE_LOAD;
            lcmd_d[i]  = src_cmd[i*CMD_W +: CMD_W];
            lspd_d[i]  = src_speed[i*SPEED_W +: SPEED_W];
         end else if (lease_q[i] != '0) begin
            lease_d[i] = lease_q[i] - LW'(1);
         end
         if (accept_en && src_valid[i] && !code_ok(src_cmd[i*CMD_W +: CMD_W]))
            cmd_reject_d = 1'b1;
      end
   end

   // Descending scan so the lowest-index live source wins.
   always_comb begin
      tgt_valid = 1'b0;
      tgt_idx   = '0;
      tgt_cmd   = CMD_STOP;
      tgt_spd   = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (lease_q[i] != '0) begin
            tgt_valid = 1'b1;
            tgt_idx   = IDX_W'(i);
            tgt_cmd   = lcmd_q[i];
            tgt_spd   = lspd_q[i];
         end
      end
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_q       <= ST_STOP;
         drive_cmd_q   <= '0;
         speed_q       <= '0;
         ramp_q        <= '0;
         cmd_changed_q <= 1'b0;
         cmd_reject_q  <= 1'b0;
         for (int i = 0; i < N_SRC; i++) begin
            lease_q[i] <= '0;
            lcmd_q[i]  <= '0;
            lspd_q[i]  <= '0;
         end
      end else begin
         state_q       <= state_d;
         drive_cmd_q   <= drive_cmd_d;
         speed_q       <= speed_d;
         ramp_q        <= ramp_d;
         cmd_changed_q <= cmd_changed_d;
         cmd_reject_q  <= cmd_reject_d;
         for (int i = 0; i < N_SRC; i++) begin
            lease_q[i] <= lease_d[i];
            lcmd_q[i]  <= lcmd_d[i];
            lspd_q[i]  <= lspd_d[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (estop) begin
         state_d = ST_ESTOP;
      end else begin
         case (state_q)
            ST_STOP:  if (tgt_cmd != CMD_STOP && tgt_spd != '0) state_d = ST_RUN;
            ST_RUN:   if (tgt_cmd != drive_cmd_q) state_d = ST_BRAKE;
            ST_BRAKE: begin
               if (tgt_cmd == drive_cmd_q) state_d = ST_RUN;
               else if (speed_q == '0)     state_d = ST_STOP;
            end
            ST_ESTOP: if (estop_clear) state_d = ST_STOP;
            default:  state_d = ST_STOP;
         endcase
      end
   end

   always_comb begin
      drive_cmd_d = drive_cmd_q;
      speed_d     = speed_q;
      ramp_d      = (ramp_q == '0) ? ramp_q : ramp_q - RW'(1);
      if (state_d == ST_ESTOP) begin
         drive_cmd_d = CMD_STOP;
         speed_d     = '0;
      end else begin
         case (state_q)
            ST_STOP: if (state_d == ST_RUN) drive_cmd_d = tgt_cmd;
            ST_RUN: begin
               if (state_d == ST_RUN && ramp_q == '0) begin
                  ramp_d = RAMP_LOAD;
                  if (speed_q < tgt_spd)      speed_d = speed_q + SPEED_W'(1);
                  else if (speed_q > tgt_spd) speed_d = speed_q - SPEED_W'(1);
               end
            end
            ST_BRAKE: begin
               if (state_d == ST_STOP) begin
                  drive_cmd_d = CMD_STOP;
               end else if (state_d == ST_BRAKE && ramp_q == '0) begin
                  ramp_d  = RAMP_LOAD;
                  speed_d = speed_q - SPEED_W'(1);
               end
            end
            default: ;
         endcase
      end
      if (state_d != state_q) ramp_d = RAMP_LOAD;
      cmd_changed_d = (drive_cmd_d != drive_cmd_q);
   end

   assign drive_cmd    = drive_cmd_q;
   assign drive_speed  = speed_q;
   assign active_src   = tgt_idx;
   assign active_valid = tgt_valid;
   assign state        = state_q;
   assign cmd_changed  = cmd_changed_q;
   assign cmd_reject   = cmd_reject_q;

endmodule
